lcd_ram_reader: RTL

- Reads stored bytes back from the HD44780-compatible character LCD over the 4-bit bus: CGRAM glyph rows or DDRAM characters.
- Used to check that the custom-object initialiser loaded each CGRAM glyph correctly, and to read the on-screen character map for game-state checks.
- Sits beside the LCD writers behind the LCD bus mux. It owns the bus only while busy=1.

---
 rtl/lcd_pkg.sv | 50 +++++
 rtl/lcd_nibble_slot.sv | 32 +++
 rtl/lcd_ram_reader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit bus blocks: command codes, busy-flag
// position, the reader state encoding and the per-slot bus drive helper.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_SET_CGRAM = 8'h40;
    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam int         LCD_BF_BIT        = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_HI,
        ST_CMD_LO,
        ST_BF_HI,
        ST_BF_LO,
        ST_RD_HI,
        ST_RD_LO,
        ST_FIN
    } rd_state_t;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic       oe;
        logic [3:0] dout;
    } lcd_bus_t;

    localparam lcd_bus_t LCD_BUS_IDLE = '0;

    // Bus levels held for the whole slot belonging to state st.
    function automatic lcd_bus_t slot_bus(input rd_state_t st, input logic [7:0] cmd);
        lcd_bus_t b;
        b = LCD_BUS_IDLE;
        case (st)
            ST_CMD_HI: b = '{rs: 1'b0, rw: 1'b0, oe: 1'b1, dout: cmd[7:4]};
            ST_CMD_LO: b = '{rs: 1'b0, rw: 1'b0, oe: 1'b1, dout: cmd[3:0]};
            ST_BF_HI,
            ST_BF_LO:  b = '{rs: 1'b0, rw: 1'b1, oe: 1'b0, dout: 4'h0};
            ST_RD_HI,
            ST_RD_LO:  b = '{rs: 1'b1, rw: 1'b1, oe: 1'b0, dout: 4'h0};
            default:   b = LCD_BUS_IDLE;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] set_addr_cmd(input logic ram_sel, input logic [6:0] addr);
        return ram_sel ? (LCD_CMD_SET_DDRAM | {1'b0, addr})
                       : (LCD_CMD_SET_CGRAM | {2'b00, addr[5:0]});
    endfunction

endpackage

// File: rtl/lcd_nibble_slot.sv
// E-strobe timing for one nibble slot: E_HALF cycles low, E_HALF cycles high.
// sample/slot_done mark the last e=1 cycle; the phase restarts while run=0.
module lcd_nibble_slot #(
    parameter int E_HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic e,
    output logic sample,
    output logic slot_done
);
    localparam int SLOT_LEN = 2 * E_HALF;
    localparam int CW       = $clog2(SLOT_LEN);

    logic [CW-1:0] phase_reg;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            phase_reg <= '0;
        end else if (phase_reg == CW'(SLOT_LEN - 1)) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_reg + CW'(1);
        end
    end

    assign e         = run && (phase_reg >= CW'(E_HALF));
    assign slot_done = run && (phase_reg == CW'(SLOT_LEN - 1));
    assign sample    = slot_done;

endmodule

// File: rtl/lcd_ram_reader.sv
// Reads CGRAM/DDRAM bytes back over the HD44780 4-bit bus: set address,
// poll the busy flag, then stream count bytes relying on LCD auto-increment.
module lcd_ram_reader #(
    parameter int E_HALF       = 1,
    parameter int BF_MAX_POLLS = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       ram_sel,
    input  logic [6:0] addr,
    input  logic [5:0] count,
    output logic       rs,
    output logic       rw,
    output logic       e,
    output logic [3:0] data_out,
    output logic       data_oe,
    input  logic [3:0] data_in,
    output logic       busy,
    output logic       rd_valid,
    output logic [7:0] rd_byte,
    output logic [5:0] rd_index,
    output logic       done,
    output logic       err
);
    import lcd_pkg::*;

    localparam int PW = $clog2(BF_MAX_POLLS + 1);

    rd_state_t     state_reg;
    lcd_bus_t      bus_reg;
    logic          busy_reg, err_reg, done_reg, rd_valid_reg, bf_reg;
    logic [7:0]    rd_byte_reg, cmd_reg;
    logic [5:0]    rd_index_reg, idx_reg, count_reg;
    logic [3:0]    hi_reg;
    logic [PW-1:0] poll_reg;
    logic          sample, slot_done;

    // The slot timer only runs while the bus is owned, so e drops the cycle busy does.
    lcd_nibble_slot #(.E_HALF(E_HALF)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .run       (busy_reg),
        .e         (e),
        .sample    (sample),
        .slot_done (slot_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            bus_reg      <= LCD_BUS_IDLE;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            done_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
            bf_reg       <= 1'b0;
            rd_byte_reg  <= '0;
            cmd_reg      <= '0;
            rd_index_reg <= '0;
            idx_reg      <= '0;
            count_reg    <= '0;
            hi_reg       <= '0;
            poll_reg     <= '0;
        end else begin
            rd_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_FIN: begin
                    state_reg <= ST_IDLE;
                    if (req && count != 6'd0) begin
                        state_reg <= ST_CMD_HI;
                        cmd_reg   <= set_addr_cmd(ram_sel, addr);
                        bus_reg   <= slot_bus(ST_CMD_HI, set_addr_cmd(ram_sel, addr));
                        count_reg <= count;
                        idx_reg   <= '0;
                        poll_reg  <= '0;
                        busy_reg  <= 1'b1;
                        err_reg   <= 1'b0;
                    end
                end
                ST_CMD_HI: if (slot_done) begin
                    state_reg <= ST_CMD_LO;
                    bus_reg   <= slot_bus(ST_CMD_LO, cmd_reg);
                end
                ST_CMD_LO: if (slot_done) begin
                    state_reg <= ST_BF_HI;
                    bus_reg   <= slot_bus(ST_BF_HI, cmd_reg);
                end
                ST_BF_HI: if (sample) begin
                    bf_reg    <= data_in[LCD_BF_BIT];
                    state_reg <= ST_BF_LO;
                    bus_reg   <= slot_bus(ST_BF_LO, cmd_reg);
                end
                ST_BF_LO: if (slot_done) begin
                    if (!bf_reg) begin
                        state_reg <= ST_RD_HI;
                        bus_reg   <= slot_bus(ST_RD_HI, cmd_reg);
                    end else if (poll_reg == PW'(BF_MAX_POLLS - 1)) begin
                        // LCD never came ready: release the bus and flag it.
                        err_reg   <= 1'b1;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                        bus_reg   <= LCD_BUS_IDLE;
                    end else begin
                        poll_reg  <= poll_reg + PW'(1);
                        state_reg <= ST_BF_HI;
                        bus_reg   <= slot_bus(ST_BF_HI, cmd_reg);
                    end
                end
                ST_RD_HI: if (sample) begin
                    hi_reg    <= data_in;
                    state_reg <= ST_RD_LO;
                    bus_reg   <= slot_bus(ST_RD_LO, cmd_reg);
                end
                ST_RD_LO: if (sample) begin
                    rd_byte_reg  <= {hi_reg, data_in};
                    rd_index_reg <= idx_reg;
                    rd_valid_reg <= 1'b1;
                    if (idx_reg == count_reg - 6'd1) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_FIN;
                        bus_reg   <= LCD_BUS_IDLE;
                    end else begin
                        idx_reg   <= idx_reg + 6'd1;
                        state_reg <= ST_RD_HI;
                        bus_reg   <= slot_bus(ST_RD_HI, cmd_reg);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rs       = bus_reg.rs;
    assign rw       = bus_reg.rw;
    assign data_out = bus_reg.dout;
    assign data_oe  = bus_reg.oe;
    assign busy     = busy_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_byte  = rd_byte_reg;
    assign rd_index = rd_index_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule
